// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the datamemory block.
// Valid/ready semantics: a transfer happens on a rising edge where rN_req & rN_gnt; while req is high and gnt low the requester holds we/addr/wdata stable.
interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          r0_req;
    logic          r0_we;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt;
    logic [DW-1:0] r0_rdata;
    logic          r0_valid;

    logic          r1_req;
    logic          r1_we;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt;
    logic [DW-1:0] r1_rdata;
    logic          r1_valid;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata;
    logic          cpu_stall;

    // Arbiter view.
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rdata, r0_valid,
        output r1_gnt, r1_rdata, r1_valid,
        output mem_addr, mem_wdata, mem_wren, cpu_stall
    );

    // Requesters plus datamemory view.
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rdata, r0_valid,
        input  r1_gnt, r1_rdata, r1_valid,
        input  mem_addr, mem_wdata, mem_wren, cpu_stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU (port 0) has priority,
// the debug/IO loader (port 1) is guaranteed a slot after MAX_BURST CPU grants.
module dmem_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus,
    output logic [1:0]     o_dbg_state,
    output logic [3:0]     o_dbg_burst_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_burst_cnt;
    logic          w_fair;
    logic          w_gnt0;
    logic          w_gnt1;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_valid0;
    logic          r_valid1;

    assign w_fair = bus.r1_req && (r_burst_cnt == BURST_MAX);

    // Ungated grant feeds the internal flops; reset only gates the visible outputs,
    // so the flops already hold their reset values while rst_n is low.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_fair) begin
            w_gnt1 = 1'b1;
        end else if (bus.r0_req) begin
            w_gnt0 = 1'b1;
        end else if (bus.r1_req) begin
            w_gnt1 = 1'b1;
        end
    end

    assign bus.r0_gnt    = w_gnt0 & rst_n;
    assign bus.r1_gnt    = w_gnt1 & rst_n;
    assign bus.cpu_stall = bus.r0_req & ~bus.r0_gnt;

    assign bus.mem_addr  = w_gnt1 ? bus.r1_addr  : bus.r0_addr;
    assign bus.mem_wdata = w_gnt1 ? bus.r1_wdata : bus.r0_wdata;
    assign bus.mem_wren  = rst_n & ((w_gnt0 & bus.r0_we) | (w_gnt1 & bus.r1_we));

    always_comb begin
        w_state_nxt = IDLE;
        if (w_gnt0) begin
            w_state_nxt = OWN0;
        end else if (w_gnt1) begin
            w_state_nxt = OWN1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counts CPU grants that made port 1 wait; saturates at the burst limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
        end else if (!bus.r1_req || w_gnt1) begin
            r_burst_cnt <= 4'd0;
        end else if (w_gnt0 && (r_burst_cnt < BURST_MAX)) begin
            r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata0 <= '0;
            r_valid0 <= 1'b0;
            r_rdata1 <= '0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= w_gnt0 & ~bus.r0_we;
            r_valid1 <= w_gnt1 & ~bus.r1_we;
            if (w_gnt0 && !bus.r0_we) begin
                r_rdata0 <= bus.mem_rdata;
            end
            if (w_gnt1 && !bus.r1_we) begin
                r_rdata1 <= bus.mem_rdata;
            end
        end
    end

    assign bus.r0_rdata = r_rdata0;
    assign bus.r0_valid = r_valid0;
    assign bus.r1_rdata = r_rdata1;
    assign bus.r1_valid = r_valid1;

    assign o_dbg_state     = r_state;
    assign o_dbg_burst_cnt = r_burst_cnt;

endmodule
